// File: rtl/wb_sequencer_pkg.sv
// Shared widths, write-back payload struct and source-select enum for wb_sequencer.
// WB_LOAD_BYPASS_EN (see wb_sequencer.sv) selects the direct load-to-output path.
package wb_sequencer_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned NUM_REGS     = 1 << REG_AW;
  localparam int unsigned LQ_DEPTH_DEF = 4;

  localparam logic [REG_AW-1:0] X0_IDX = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ALU    = 2'd1,
    SRC_FIFO   = 2'd2,
    SRC_BYPASS = 2'd3
  } wb_src_e;

  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return rd == X0_IDX;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy counter.
// Push and pop may coincide at any occupancy; no read-during-write bypass.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push needs when full.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_sequencer.sv
// Register-file write-back sequencer: ALU/load merge, load queue, pending-load scoreboard.
// Optional macro WB_LOAD_BYPASS_EN lets a load hit the output flops directly when idle.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              raw_stall,
  output logic              write,
  output logic [REG_AW-1:0] wrAddr,
  output logic [XLEN-1:0]   wrData
);

  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

  wb_entry_t         ld_entry, fifo_head;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              ld_accept;
  wb_src_e           src;

  logic              write_q, write_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign ld_entry  = '{rd: ld_rd, data: ld_data};
  assign ld_ready  = ~fifo_full;
  assign ld_accept = ld_valid & ~fifo_full;

  // Occupancy is exposed by the queue but only full/empty steer this level.
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;

  wb_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_lq (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (ld_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Output source priority: ALU, then queued loads, then (optionally) a fresh load.
  always_comb begin
    src = SRC_NONE;
    if (alu_valid) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end
`ifdef WB_LOAD_BYPASS_EN
    else if (ld_accept) begin
      src = SRC_BYPASS;
    end
`endif
  end

  assign fifo_pop  = (src == SRC_FIFO);
  assign fifo_push = ld_accept & (src != SRC_BYPASS);

  // Next output register and scoreboard; a same-edge set beats the load's clear.
  always_comb begin
    write_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pending_d = pending_q;
    case (src)
      SRC_ALU: begin
        write_d   = ~is_x0(alu_rd);
        wr_addr_d = alu_rd;
        wr_data_d = alu_data;
      end
      SRC_FIFO: begin
        write_d   = ~is_x0(fifo_head.rd);
        wr_addr_d = fifo_head.rd;
        wr_data_d = fifo_head.data;
        pending_d[fifo_head.rd] = 1'b0;
      end
      SRC_BYPASS: begin
        write_d   = ~is_x0(ld_entry.rd);
        wr_addr_d = ld_entry.rd;
        wr_data_d = ld_entry.data;
        pending_d[ld_entry.rd] = 1'b0;
      end
      default: ;
    endcase
    if (ld_issue) pending_d[ld_issue_rd] = 1'b1;
    pending_d[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      write_q   <= write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign raw_stall = pending_q[rs1] | pending_q[rs2];
  assign write     = write_q;
  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;

endmodule
